// File: rtl/btn_gesture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_gesture_pkg
// Brief    : Shared state encoding and default tick constants for the button
//            gesture classifier and other button/UI blocks.
// Revision : 1.0 - initial release
// ============================================================================
package btn_gesture_pkg;

    // 3-bit binary state encoding; codes 5..7 are unused and recover to IDLE
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS1    = 3'd1,
        S_LONG_HELD = 3'd2,
        S_GAP       = 3'd3,
        S_PRESS2    = 3'd4
    } state_t;

    // Default timing at 100 MHz: 0.5 s long-press, 0.25 s double-press window
    localparam int c_LONG_TICKS_DEF = 50_000_000;
    localparam int c_GAP_TICKS_DEF  = 25_000_000;
    localparam int c_CNT_W_DEF      = 26;

endpackage : btn_gesture_pkg
`default_nettype wire

// File: rtl/btn_gesture_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_gesture_edge
// Brief    : Registers the previous button level and derives rise/fall
//            strobes. Previous level resets to 1 so a button held through
//            reset is not mistaken for a fresh press.
// Revision : 1.0 - initial release
// ============================================================================
module btn_gesture_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    // Track last sampled level; reset value 1 suppresses a phantom rise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_rise = i_btn & ~r_prev;
    assign o_fall = ~i_btn & r_prev;

endmodule : btn_gesture_edge
`default_nettype wire

// File: rtl/btn_gesture.sv
`default_nettype none
// ============================================================================
// Module   : btn_gesture
// Brief    : Classifies debounced button presses into one-cycle short, long
//            and double press events, plus holding/busy status levels.
// Revision : 1.0 - initial release
// ============================================================================
module btn_gesture
    import btn_gesture_pkg::*;
#(
    parameter int LONG_TICKS = c_LONG_TICKS_DEF,
    parameter int GAP_TICKS  = c_GAP_TICKS_DEF,
    parameter int CNT_W      = c_CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_state,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic holding,
    output logic busy
);

    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

    logic             w_rise;
    logic             w_fall;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_short;
    logic             r_long;
    logic             r_double;
    logic             r_holding;
    logic             r_busy;

    btn_gesture_edge u_edge (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (btn_state),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Gesture FSM with its tick counter and registered outputs; status levels
    // are written alongside each transition so they track the new state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_double  <= 1'b0;
            r_holding <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // Pulses last one cycle; counter saturates unless a transition clears it
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state <= S_PRESS1;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_PRESS1: begin
                    // A release on the timeout edge still counts as a short press
                    if (w_fall) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_LONG_LAST) begin
                        r_state   <= S_LONG_HELD;
                        r_cnt     <= '0;
                        r_long    <= 1'b1;
                        r_holding <= 1'b1;
                    end
                end
                S_LONG_HELD: begin
                    if (w_fall) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_holding <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                S_GAP: begin
                    // A second press on the timeout edge still counts as double
                    if (w_rise) begin
                        r_state  <= S_PRESS2;
                        r_cnt    <= '0;
                        r_double <= 1'b1;
                    end else if (r_cnt == c_GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_short <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_PRESS2: begin
                    if (w_fall) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_holding <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign short_press  = r_short;
    assign long_press   = r_long;
    assign double_press = r_double;
    assign holding      = r_holding;
    assign busy         = r_busy;

endmodule : btn_gesture
`default_nettype wire

// File: tb/tb_btn_gesture.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_gesture
// Brief    : Self-checking bench for btn_gesture with short tick counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_gesture;

    localparam int c_LONG = 8;
    localparam int c_GAP  = 4;

    logic clk;
    logic reset;
    logic btn_state;
    logic short_press;
    logic long_press;
    logic double_press;
    logic holding;
    logic busy;

    int n_cmp;
    int n_bad;
    int k;      // index of the most recent rising clock edge

    // Expected outputs, updated by the gesture model at each rising edge
    logic e_short, e_long, e_double, e_hold, e_busy;

    // Per-test pulse recorders
    int sh_n, lg_n, db_n, sh_e, lg_e, db_e;

    btn_gesture #(
        .LONG_TICKS (c_LONG),
        .GAP_TICKS  (c_GAP),
        .CNT_W      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_state    (btn_state),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .holding      (holding),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0b, expected %0b", name, k, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Gesture model built from timestamps of the press/release edges
    initial begin : model
        bit prev, active, held_long, second, b, rise, fall;
        int t_press, t_rel;
        prev = 1; active = 0; held_long = 0; second = 0;
        t_press = 0; t_rel = -1; k = 0;
        {e_short, e_long, e_double, e_hold, e_busy} = '0;
        forever begin
            @(posedge clk);
            k++;
            {e_short, e_long, e_double} = '0;
            if (!reset) begin
                prev = 1; active = 0; held_long = 0; second = 0;
            end else begin
                b    = btn_state;
                rise = b && !prev;
                fall = !b && prev;
                prev = b;
                if (!active) begin
                    if (rise) begin
                        active = 1; t_press = k; t_rel = -1;
                        held_long = 0; second = 0;
                    end
                end else if (second || held_long) begin
                    if (fall) active = 0;
                end else if (t_rel < 0) begin
                    if (fall) t_rel = k;
                    else if (k - t_press == c_LONG) begin
                        e_long = 1; held_long = 1;
                    end
                end else begin
                    if (rise && (k - t_rel <= c_GAP)) begin
                        e_double = 1; second = 1;
                    end else if (k - t_rel == c_GAP) begin
                        e_short = 1; active = 0;
                    end
                end
            end
            e_hold = active && held_long;
            e_busy = active;
        end
    end

    // Per-cycle comparison against the model plus pulse recording
    initial begin : compare
        forever begin
            @(negedge clk);
            chk("short_press",  short_press,  e_short);
            chk("long_press",   long_press,   e_long);
            chk("double_press", double_press, e_double);
            chk("holding",      holding,      e_hold);
            chk("busy",         busy,         e_busy);
            if (short_press)  begin sh_n++; sh_e = k; end
            if (long_press)   begin lg_n++; lg_e = k; end
            if (double_press) begin db_n++; db_e = k; end
        end
    end

    task automatic clear_rec();
        sh_n = 0; lg_n = 0; db_n = 0; sh_e = -1; lg_e = -1; db_e = -1;
    endtask

    // Set the button so that rising edge e samples the value v
    task automatic drive(input int e, input logic v);
        while (k < e - 1) @(negedge clk);
        btn_state = v;
    endtask

    task automatic wait_edge(input int e);
        while (k < e) @(negedge clk);
    endtask

    task automatic chk_counts(input string name, input int s, input int l, input int d);
        chk_int({name, " short count"},  sh_n, s);
        chk_int({name, " long count"},   lg_n, l);
        chk_int({name, " double count"}, db_n, d);
    endtask

    initial begin : stim
        int t0;
        n_cmp = 0; n_bad = 0;
        clear_rec();
        reset = 1'b0;
        btn_state = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset holding", holding, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // 1: short press
        t0 = k; clear_rec();
        drive(t0 + 10, 1'b1); drive(t0 + 13, 1'b0);
        wait_edge(t0 + 25);
        chk_int("t1 short edge", sh_e - t0, 17);
        chk_counts("t1", 1, 0, 0);

        // 2: long press held 20 cycles
        t0 = k; clear_rec();
        drive(t0 + 10, 1'b1);
        wait_edge(t0 + 20);
        chk("t2 holding mid", holding, 1'b1);
        drive(t0 + 30, 1'b0);
        wait_edge(t0 + 31);
        chk("t2 busy after release", busy, 1'b0);
        wait_edge(t0 + 40);
        chk_int("t2 long edge", lg_e - t0, 18);
        chk_counts("t2", 0, 1, 0);

        // 3: double press
        t0 = k; clear_rec();
        drive(t0 + 10, 1'b1); drive(t0 + 12, 1'b0);
        drive(t0 + 14, 1'b1); drive(t0 + 16, 1'b0);
        wait_edge(t0 + 15);
        chk("t3 busy in second press", busy, 1'b1);
        wait_edge(t0 + 25);
        chk_int("t3 double edge", db_e - t0, 14);
        chk_counts("t3", 0, 0, 1);

        // 4a: second rise exactly at release+GAP
        t0 = k; clear_rec();
        drive(t0 + 10, 1'b1); drive(t0 + 13, 1'b0);
        drive(t0 + 17, 1'b1); drive(t0 + 19, 1'b0);
        wait_edge(t0 + 30);
        chk_int("t4a double edge", db_e - t0, 17);
        chk_counts("t4a", 0, 0, 1);

        // 4b: release at press+7
        t0 = k; clear_rec();
        drive(t0 + 10, 1'b1); drive(t0 + 17, 1'b0);
        wait_edge(t0 + 30);
        chk_int("t4b short edge", sh_e - t0, 21);
        chk_counts("t4b", 1, 0, 0);

        // 4c: release on the same edge the long timeout would hit
        t0 = k; clear_rec();
        drive(t0 + 10, 1'b1); drive(t0 + 18, 1'b0);
        wait_edge(t0 + 30);
        chk_int("t4c short edge", sh_e - t0, 22);
        chk_counts("t4c", 1, 0, 0);

        // 5: button held while reset releases
        t0 = k; clear_rec();
        reset = 1'b0; btn_state = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        t0 = k;
        drive(t0 + 10, 1'b0);
        wait_edge(t0 + 18);
        chk_counts("t5 held", 0, 0, 0);
        drive(t0 + 20, 1'b1); drive(t0 + 22, 1'b0);
        wait_edge(t0 + 30);
        chk_int("t5 short edge", sh_e - t0, 26);
        chk_counts("t5", 1, 0, 0);

        // 6a: reset asserted asynchronously during the first press
        t0 = k; clear_rec();
        drive(t0 + 10, 1'b1);
        wait_edge(t0 + 12);
        chk("t6a busy before reset", busy, 1'b1);
        #2 reset = 1'b0;
        #1 chk("t6a busy async", busy, 1'b0);
        btn_state = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        t0 = k;
        wait_edge(t0 + 15);
        chk_counts("t6a", 0, 0, 0);

        // 6b: reset asserted asynchronously in the release window
        t0 = k; clear_rec();
        drive(t0 + 10, 1'b1); drive(t0 + 12, 1'b0);
        wait_edge(t0 + 14);
        chk("t6b busy before reset", busy, 1'b1);
        #2 reset = 1'b0;
        #1 chk("t6b busy async", busy, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        t0 = k;
        wait_edge(t0 + 15);
        chk_counts("t6b", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_btn_gesture
`default_nettype wire
